// File: rtl/ram8_16.sv
// ram8_16: 8 x WIDTH Hack RAM8 with clocked write, combinational read and a
// self-sequenced clear sweep. The write strobe is decoded through dmux8way_gate.
`default_nettype none

module dmux8way_gate (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  logic lo_half;
  logic hi_half;

  // Two-level tree: sel[2] splits the halves, sel[1:0] picks within a half.
  assign lo_half = in & ~sel[2];
  assign hi_half = in &  sel[2];

  assign a = lo_half & ~sel[1] & ~sel[0];
  assign b = lo_half & ~sel[1] &  sel[0];
  assign c = lo_half &  sel[1] & ~sel[0];
  assign d = lo_half &  sel[1] &  sel[0];
  assign e = hi_half & ~sel[1] & ~sel[0];
  assign f = hi_half & ~sel[1] &  sel[0];
  assign g = hi_half &  sel[1] & ~sel[0];
  assign h = hi_half &  sel[1] &  sel[0];
endmodule

module ram8_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       ptr_q;
  logic [2:0]       ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             load_taken;
  logic [7:0]       ld;

  // A write is only taken in IDLE and only when no clear shares the edge.
  assign load_taken = load & (state_q == IDLE) & ~clear;

  dmux8way_gate u_dmux (
    .in  (load_taken),
    .sel (address),
    .a   (ld[0]),
    .b   (ld[1]),
    .c   (ld[2]),
    .d   (ld[3]),
    .e   (ld[4]),
    .f   (ld[5]),
    .g   (ld[6]),
    .h   (ld[7])
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = 3'd0;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (ld[i]) begin
              mem_d[i] = in;
            end
          end
        end
      end
      SWEEP: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + 3'd1;
        if (ptr_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out  = mem_q[address];
  assign busy = (state_q == SWEEP);
endmodule

`default_nettype wire

// File: tb/tb_ram8_16.sv
// tb_ram8_16: directed self-checking bench for ram8_16.
`default_nettype none

module tb_ram8_16;
  logic        clk;
  logic        reset;
  logic [15:0] in_w;
  logic [2:0]  address;
  logic        load;
  logic        clear;
  logic [15:0] out_w;
  logic        busy;

  int tests;
  int fails;
  logic [15:0] expv [8];

  ram8_16 #(.WIDTH(16), .DEPTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_w),
    .address (address),
    .load    (load),
    .clear   (clear),
    .out     (out_w),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [2:0] a, input logic [15:0] e);
    // drives address and compares inline at the caller's request
    address = a;
    #1;
    tests++;
    if (out_w !== e) begin
      fails++;
      $display("FAIL %s addr=%0d out=%h expected=%h", name, a, out_w, e);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    address = a; in_w = d; load = 1'b1;
    tick();
    load = 1'b0;
    expv[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; clear = 1'b0; in_w = 16'h0; address = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy busy=%b expected=0", busy); end
    for (int i = 0; i < 8; i++) begin
      expv[i] = 16'h0;
      chk_out("reset_read", 3'(i), 16'h0000);
    end
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < 8; i++) write(3'(i), 16'h1000 + 16'(i));
    for (int i = 7; i >= 0; i--) chk_out("readback", 3'(i), 16'h1000 + 16'(i));
    write(3'd3, 16'hAAAA);
    for (int i = 0; i < 8; i++)
      chk_out("write3_isolation", 3'(i), (i == 3) ? 16'hAAAA : 16'h1000 + 16'(i));
  endtask

  task automatic test_decode_isolation();
    write(3'd5, 16'hBEEF);
    in_w = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      address = 3'(i * 2);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i == 5) ? 16'hBEEF : (i == 3) ? 16'hAAAA : 16'h1000 + 16'(i);
      chk_out("decode_isolation", 3'(i), e);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cycles++;
      chk_out("sweep_unswept", 3'(k), expv[k]);
      if (k < 7) chk_out("sweep_next_unswept", 3'(k + 1), expv[k + 1]);
      tick();
      chk_out("sweep_swept", 3'(k), 16'h0000);
      expv[k] = 16'h0;
    end
    tests++;
    if (busy_cycles != 8 || busy !== 1'b0) begin
      fails++;
      $display("FAIL sweep_busy_len cycles=%0d busy_after=%b expected=8,0", busy_cycles, busy);
    end
    for (int i = 0; i < 8; i++) chk_out("sweep_all_zero", 3'(i), 16'h0000);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 8; i++) write(3'(i), 16'h2000 + 16'(i));
    address = 3'd2; in_w = 16'h1234; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL prio_busy busy=%b expected=1", busy); end
    chk_out("prio_no_write", 3'd2, 16'h2002);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin address = 3'd6; in_w = 16'h5555; load = 1'b1; clear = 1'b1; end
      else begin load = 1'b0; clear = 1'b0; end
      tick();
    end
    load = 1'b0; clear = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL prio_end_busy busy=%b expected=0", busy); end
    chk_out("prio_entry6", 3'd6, 16'h0000);
    chk_out("prio_entry2", 3'd2, 16'h0000);
    for (int i = 0; i < 8; i++) expv[i] = 16'h0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) write(3'(i), 16'h3000 + 16'(i));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    address = 3'd7;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL async_busy busy=%b expected=0", busy); end
    tests++;
    if (out_w !== 16'h0000) begin fails++; $display("FAIL async_out out=%h expected=0000", out_w); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL async_idle busy=%b expected=0", busy); end
    write(3'd4, 16'h00AA);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL async_write_busy busy=%b expected=0", busy); end
    chk_out("async_readback", 3'd4, 16'h00AA);
    chk_out("async_other", 3'd3, 16'h0000);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_readback();
    test_decode_isolation();
    test_clear_sweep();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d expected completion", tests);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
